// File: rtl/pkg_audio.sv
// Shared types and limits for the audio serial (I2S / left-justified) codec driver.
package pkg_audio;

   typedef enum logic {
      AUDIO_MODE_I2S = 1'b0,
      AUDIO_MODE_LJ  = 1'b1
   } audio_mode_e;

   localparam int AUDIO_WIDTH_MIN = 16;
   localparam int AUDIO_WIDTH_MAX = 32;

   // Slot bit carrying the channel MSB: I2S delays the data one BCLK behind the LRCK edge.
   function automatic int data_offset(audio_mode_e mode);
      return (mode == AUDIO_MODE_I2S) ? 1 : 0;
   endfunction

endpackage

// File: rtl/drv_audio_i2s_clk.sv
// Bit-clock generator: BCLK, its one-cycle fall/rise strobes, the frame bit counter and LRCK.
module drv_audio_i2s_clk #(
   parameter int P_SLOT     = 32,
   parameter int P_BCLK_DIV = 17,
   parameter int P_CNT_W    = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_bclk,
   output logic               o_fall,
   output logic               o_rise,
   output logic               o_frame_start,
   output logic [P_CNT_W-1:0] o_cnt,
   output logic               o_lrck
);

   localparam int                 DIV_W     = $clog2(P_BCLK_DIV);
   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(P_BCLK_DIV - 1);
   localparam logic [P_CNT_W-1:0] CNT_LAST  = P_CNT_W'(2 * P_SLOT - 1);
   localparam logic [P_CNT_W-1:0] CNT_RIGHT = P_CNT_W'(P_SLOT);

   logic [DIV_W-1:0]   div_q;
   logic               bclk_q;
   logic               lrck_q;
   logic               tick;
   logic [P_CNT_W-1:0] cnt_q;
   logic [P_CNT_W-1:0] cnt_nxt;

   assign tick          = (div_q == DIV_LAST);
   assign o_rise        = tick && !bclk_q;
   assign o_fall        = tick && bclk_q;
   assign o_frame_start = o_fall && (cnt_q == CNT_LAST);
   assign cnt_nxt       = (cnt_q == CNT_LAST) ? '0 : cnt_q + P_CNT_W'(1);

   // The counter parks on the last frame bit in reset so the first fall wraps it and opens a left slot.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
         cnt_q  <= CNT_LAST;
         lrck_q <= 1'b0;
      end else begin
         div_q <= tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            bclk_q <= !bclk_q;
         end
         if (o_fall) begin
            cnt_q  <= cnt_nxt;
            lrck_q <= (cnt_nxt >= CNT_RIGHT);
         end
      end
   end

   assign o_bclk = bclk_q;
   assign o_cnt  = cnt_q;
   assign o_lrck = lrck_q;

endmodule

// File: rtl/drv_audio_i2s.sv
// Audio codec serial driver: DAC holding/shift datapath with valid/ready handshake, ADC deserialiser, XCK.
module drv_audio_i2s
   import pkg_audio::*;
#(
   parameter int          P_WIDTH    = 16,
   parameter int          P_SLOT     = 32,
   parameter int          P_BCLK_DIV = 17,
   parameter int          P_XCK_DIV  = 1,
   parameter audio_mode_e P_MODE     = AUDIO_MODE_I2S
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   output logic                    o_drv_xck,
   output logic                    o_drv_bclk,
   output logic                    o_drv_dac_dat,
   output logic                    o_drv_dac_clrck,
   input  logic                    i_drv_adc_dat,
   output logic                    o_drv_adc_clrck,
   input  logic [1:0][P_WIDTH-1:0] i_dat,
   input  logic                    i_val,
   output logic                    o_rdy,
   output logic [1:0][P_WIDTH-1:0] o_dat,
   output logic                    o_val,
   input  logic                    i_mute,
   output logic                    o_underrun
);

   localparam int                FRAME_BITS = 2 * P_SLOT;
   localparam int                CNT_W      = $clog2(FRAME_BITS);
   localparam int                OFF        = data_offset(P_MODE);
   localparam int                PAD        = P_SLOT - P_WIDTH - OFF;
   localparam int                XCK_W      = (P_XCK_DIV > 1) ? $clog2(P_XCK_DIV) : 1;
   localparam logic [CNT_W-1:0]  SLOT_LEN   = CNT_W'(P_SLOT);
   localparam logic [CNT_W-1:0]  DATA_OFF   = CNT_W'(OFF);
   localparam logic [CNT_W-1:0]  DATA_LEN   = CNT_W'(P_WIDTH);
   localparam logic [CNT_W-1:0]  LSB_POS    = CNT_W'(OFF + P_WIDTH - 1);
   localparam logic [XCK_W-1:0]  XCK_LAST   = XCK_W'(P_XCK_DIV - 1);

   logic                    bclk;
   logic                    bclk_fall;
   logic                    bclk_rise;
   logic                    frame_start;
   logic [CNT_W-1:0]        bit_cnt;
   logic                    lrck;

   logic [XCK_W-1:0]        xck_cnt;
   logic                    xck_q;

   logic                    rdy_en;
   logic                    hold_full;
   logic [1:0][P_WIDTH-1:0] hold_q;
   logic                    underrun_q;
   logic                    xfer;
   logic                    load_zero;
   logic [1:0][P_WIDTH-1:0] load_pair;
   logic [P_SLOT-1:0]       slot_l;
   logic [P_SLOT-1:0]       slot_r;
   logic [FRAME_BITS-1:0]   frame_img;
   logic [FRAME_BITS-1:0]   shift_q;
   logic                    dac_q;

   logic                    frame_act;
   logic                    ch_right;
   logic [CNT_W-1:0]        slot_bit;
   logic [CNT_W-1:0]        data_idx;
   logic                    in_data;
   logic [P_WIDTH-1:0]      adc_sh;
   logic [P_WIDTH-1:0]      adc_word;
   logic [P_WIDTH-1:0]      adc_left;
   logic [1:0][P_WIDTH-1:0] dat_q;
   logic                    val_q;

   drv_audio_i2s_clk #(
      .P_SLOT     (P_SLOT),
      .P_BCLK_DIV (P_BCLK_DIV),
      .P_CNT_W    (CNT_W)
   ) u_clk (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .o_bclk        (bclk),
      .o_fall        (bclk_fall),
      .o_rise        (bclk_rise),
      .o_frame_start (frame_start),
      .o_cnt         (bit_cnt),
      .o_lrck        (lrck)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         xck_cnt <= '0;
         xck_q   <= 1'b0;
      end else if (xck_cnt == XCK_LAST) begin
         xck_cnt <= '0;
         xck_q   <= !xck_q;
      end else begin
         xck_cnt <= xck_cnt + XCK_W'(1);
      end
   end

   assign o_rdy     = rdy_en && !hold_full;
   assign xfer      = i_val && o_rdy;
   assign load_pair = hold_full ? hold_q : i_dat;
   assign load_zero = i_mute || (!hold_full && !xfer);
   assign slot_l    = {{(P_SLOT - P_WIDTH){1'b0}}, load_pair[0]} << PAD;
   assign slot_r    = {{(P_SLOT - P_WIDTH){1'b0}}, load_pair[1]} << PAD;
   assign frame_img = load_zero ? '0 : {slot_l, slot_r};

   // Frame start always drains the holding register; a same-cycle transfer bypasses it.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rdy_en     <= 1'b0;
         hold_full  <= 1'b0;
         hold_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         rdy_en     <= 1'b1;
         underrun_q <= 1'b0;
         if (frame_start) begin
            hold_full  <= 1'b0;
            underrun_q <= !hold_full && !xfer;
         end else if (xfer) begin
            hold_full <= 1'b1;
            hold_q    <= i_dat;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shift_q <= '0;
         dac_q   <= 1'b0;
      end else if (frame_start) begin
         dac_q   <= frame_img[FRAME_BITS-1];
         shift_q <= {frame_img[FRAME_BITS-2:0], 1'b0};
      end else if (bclk_fall) begin
         dac_q   <= shift_q[FRAME_BITS-1];
         shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
      end
   end

   assign ch_right = (bit_cnt >= SLOT_LEN);
   assign slot_bit = ch_right ? bit_cnt - SLOT_LEN : bit_cnt;
   assign data_idx = slot_bit - DATA_OFF;
   assign in_data  = (data_idx < DATA_LEN);
   assign adc_word = {adc_sh[P_WIDTH-2:0], i_drv_adc_dat};

   // ADC sampling waits for the first full frame so the rise before it cannot yield a stray sample.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         frame_act <= 1'b0;
         adc_sh    <= '0;
         adc_left  <= '0;
         dat_q     <= '0;
         val_q     <= 1'b0;
      end else begin
         val_q <= 1'b0;
         if (frame_start) begin
            frame_act <= 1'b1;
         end
         if (bclk_rise && frame_act && in_data) begin
            adc_sh <= adc_word;
            if (slot_bit == LSB_POS) begin
               if (!ch_right) begin
                  adc_left <= adc_word;
               end else begin
                  dat_q <= {adc_word, adc_left};
                  val_q <= 1'b1;
               end
            end
         end
      end
   end

   assign o_drv_xck       = xck_q;
   assign o_drv_bclk      = bclk;
   assign o_drv_dac_dat   = dac_q;
   assign o_drv_dac_clrck = lrck;
   assign o_drv_adc_clrck = lrck;
   assign o_dat           = dat_q;
   assign o_val           = val_q;
   assign o_underrun      = underrun_q;

endmodule
